// File: rtl/alu_multiciclo_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_multiciclo_if                                               |
// | Brief    : Handshake/operand/result bundle between control and the ALU.    |
// |            Optional macro ALU_OVERFLOW_EN adds the overflow signal.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface alu_multiciclo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       aluControl;
  logic [WIDTH-1:0] readData1;
  logic [WIDTH-1:0] saidaMuxReg;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] aluResult;
  logic [WIDTH-1:0] aluResultHi;
  logic             zero;
`ifdef ALU_OVERFLOW_EN
  logic             overflow;
`endif

  modport master (
    output start, aluControl, readData1, saidaMuxReg,
    input  busy, done, aluResult, aluResultHi, zero
`ifdef ALU_OVERFLOW_EN
    , input overflow
`endif
  );

  modport slave (
    input  start, aluControl, readData1, saidaMuxReg,
    output busy, done, aluResult, aluResultHi, zero
`ifdef ALU_OVERFLOW_EN
    , output overflow
`endif
  );
endinterface
`default_nettype wire

// File: rtl/alu_multiciclo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_multiciclo                                                  |
// | Brief    : Registered multi-cycle ALU: single-cycle logic/arith ops plus   |
// |            iterative MULU/DIVU. Optional macro ALU_OVERFLOW_EN.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_multiciclo #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input wire logic        clock,
  input wire logic        reset,
  alu_multiciclo_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] res_q, res_d, reshi_q, reshi_d;
  logic             zero_q, zero_d;
`ifdef ALU_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic [WIDTH-1:0] w_a, w_b, w_sum, w_diff, w_single;
  logic             w_iterative, w_last;
  logic [WIDTH:0]   w_mul_sum, w_rem, w_rem_sub;
  logic [WIDTH-1:0] w_step_hi, w_step_lo;

  assign w_a         = bus.readData1;
  assign w_b         = bus.saidaMuxReg;
  assign w_sum       = w_a + w_b;
  assign w_diff      = w_a - w_b;
  assign w_iterative = (bus.aluControl == OP_MULU) ||
                       ((bus.aluControl == OP_DIVU) && (w_b != '0));
  assign w_last      = (cnt_q == CNT_W'(1));

  always_comb begin
    w_single = '0;
    case (bus.aluControl)
      OP_AND:  w_single = w_a & w_b;
      OP_OR:   w_single = w_a | w_b;
      OP_ADD:  w_single = w_sum;
      OP_SUB:  w_single = w_diff;
      OP_SLT:  w_single = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      OP_NOR:  w_single = ~(w_a | w_b);
      default: w_single = '0;
    endcase
  end

  // One iteration: shift-add multiply (right shift) or restoring divide (left shift).
  always_comb begin
    w_mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    w_rem     = {hi_q, lo_q[WIDTH-1]};
    w_rem_sub = w_rem - {1'b0, b_q};
    if (op_q == OP_MULU) begin
      w_step_hi = w_mul_sum[WIDTH:1];
      w_step_lo = {w_mul_sum[0], lo_q[WIDTH-1:1]};
    end else if (w_rem >= {1'b0, b_q}) begin
      w_step_hi = w_rem_sub[WIDTH-1:0];
      w_step_lo = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      w_step_hi = w_rem[WIDTH-1:0];
      w_step_lo = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = w_iterative ? S_CALC : S_DONE;
      S_CALC:  if (w_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy = (state_q != S_IDLE);
    bus.done = (state_q == S_DONE);
  end

  always_comb begin
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    reshi_d = reshi_q;
    zero_d  = zero_q;
`ifdef ALU_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: if (bus.start) begin
        op_d = bus.aluControl;
        a_d  = w_a;
        b_d  = w_b;
        if (w_iterative) begin
          cnt_d = CNT_W'(WIDTH);
          hi_d  = '0;
          lo_d  = (bus.aluControl == OP_MULU) ? w_b : w_a;
        end else if (bus.aluControl == OP_DIVU) begin
          res_d   = '1;
          reshi_d = w_a;
          zero_d  = 1'b0;
`ifdef ALU_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
        end else begin
          res_d   = w_single;
          reshi_d = '0;
          zero_d  = (w_single == '0);
`ifdef ALU_OVERFLOW_EN
          case (bus.aluControl)
            OP_ADD:  ovf_d = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            OP_SUB:  ovf_d = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
            default: ovf_d = 1'b0;
          endcase
`endif
        end
      end
      S_CALC: begin
        hi_d  = w_step_hi;
        lo_d  = w_step_lo;
        cnt_d = cnt_q - CNT_W'(1);
        if (w_last) begin
          res_d   = w_step_lo;
          reshi_d = w_step_hi;
          zero_d  = (w_step_lo == '0);
`ifdef ALU_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      reshi_q <= '0;
      zero_q  <= 1'b1;
`ifdef ALU_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      reshi_q <= reshi_d;
      zero_q  <= zero_d;
`ifdef ALU_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.aluResult   = res_q;
  assign bus.aluResultHi = reshi_q;
  assign bus.zero        = zero_q;
`ifdef ALU_OVERFLOW_EN
  assign bus.overflow    = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_multiciclo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_multiciclo                                               |
// | Brief    : Self-checking bench for alu_multiciclo (WIDTH=32); overflow     |
// |            checks active when ALU_OVERFLOW_EN is defined.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_alu_multiciclo;

  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [W-1:0] prev_lo = '0;
  logic [W-1:0] prev_hi = '0;

  alu_multiciclo_if #(.WIDTH(W)) bus ();

  alu_multiciclo #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from plain arithmetic on the operation definitions.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] lo, output logic [W-1:0] hi,
                                output logic ovf, output int lat);
    longint sa, sb, s, lim;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = 64'sd2147483648;
    lo = '0; hi = '0; ovf = 1'b0; lat = 1;
    case (op)
      4'b0000: lo = a & b;
      4'b0001: lo = a | b;
      4'b0010: begin lo = a + b; s = sa + sb; ovf = (s >= lim) || (s < -lim); end
      4'b0110: begin lo = a - b; s = sa - sb; ovf = (s >= lim) || (s < -lim); end
      4'b0111: lo = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: lo = ~(a | b);
      4'b1000: begin p = 64'(a) * 64'(b); lo = p[31:0]; hi = p[63:32]; lat = W + 1; end
      4'b1001: begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; lat = W + 1; end
      end
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    logic [W-1:0] elo, ehi;
    logic eovf;
    int elat, n;
    bit held;
    model(op, a, b, elo, ehi, eovf, elat);
    @(negedge clock);
    bus.start = 1'b1; bus.aluControl = op; bus.readData1 = a; bus.saidaMuxReg = b;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.aluControl  = 4'($urandom);
    bus.readData1   = $urandom;
    bus.saidaMuxReg = $urandom;
    n = 0; held = 1'b1;
    do begin
      @(negedge clock);
      n++;
      if (!bus.done && (bus.aluResult !== prev_lo || bus.aluResultHi !== prev_hi || bus.busy !== 1'b1))
        held = 1'b0;
    end while (!bus.done && n < 100);
    chk({tag, "_latency"}, 64'(n), 64'(elat));
    chk({tag, "_result"}, 64'(bus.aluResult), 64'(elo));
    chk({tag, "_resultHi"}, 64'(bus.aluResultHi), 64'(ehi));
    chk({tag, "_zero"}, 64'(bus.zero), 64'(elo == 0));
    chk({tag, "_hold_busy"}, 64'(held), 64'd1);
`ifdef ALU_OVERFLOW_EN
    chk({tag, "_overflow"}, 64'(bus.overflow), 64'(eovf));
`endif
    @(negedge clock);
    chk({tag, "_idle_after"}, 64'({bus.done, bus.busy}), 64'd0);
    prev_lo = elo;
    prev_hi = ehi;
  endtask

  initial begin
    logic [3:0] codes [10];
    int dn, first, second;
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;

    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
              4'b1100, 4'b1000, 4'b1001, 4'b1111, 4'b0101};
    bus.start = 1'b0; bus.aluControl = '0; bus.readData1 = '0; bus.saidaMuxReg = '0;

    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset_state", 64'({bus.busy, bus.done, bus.zero}), 64'b001);
    chk("reset_result", 64'({bus.aluResultHi, bus.aluResult}), 64'd0);
`ifdef ALU_OVERFLOW_EN
    chk("reset_overflow", 64'(bus.overflow), 64'd0);
`endif
    reset = 1'b0;

    run_op(4'b0010, 32'd1, 32'd2, "add_pre");

    // Abort a multiply 10 cycles in with an asynchronous reset
    @(negedge clock);
    bus.start = 1'b1; bus.aluControl = 4'b1000;
    bus.readData1 = 32'h1234_5679; bus.saidaMuxReg = 32'h0000_ABCD;
    @(posedge clock); #1;
    bus.start = 1'b0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.done) dn++;
    end
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", 64'(bus.busy), 64'd0);
    chk("rst_mid_result", 64'(bus.aluResult), 64'd0);
    chk("rst_mid_zero", 64'(bus.zero), 64'd1);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.done) dn++;
    end
    chk("rst_mid_no_done", 64'(dn), 64'd0);
    prev_lo = '0; prev_hi = '0;
    run_op(4'b0010, 32'd5, 32'd7, "add_5_7");

    run_op(4'b0110, 32'd3, 32'd3, "sub_3_3");
    run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, "slt_m1_1");
    run_op(4'b1100, 32'd0, 32'd0, "nor_0_0");
    run_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulu_max");
    run_op(4'b1001, 32'd100, 32'd7, "divu_100_7");
    run_op(4'b1001, 32'd100, 32'd0, "divu_by_0");
    run_op(4'b0011, 32'hDEAD_BEEF, 32'h1234_5678, "bad_code");
`ifdef ALU_OVERFLOW_EN
    run_op(4'b0010, 32'h7FFF_FFFF, 32'd1, "ovf_add");
    run_op(4'b0110, 32'h8000_0000, 32'd1, "ovf_sub");
    run_op(4'b0000, 32'hFFFF_FFFF, 32'h0F0F_0F0F, "ovf_and");
`endif

    // A second start during DIVU must be ignored
    @(negedge clock);
    bus.start = 1'b1; bus.aluControl = 4'b1001; bus.readData1 = 32'd100; bus.saidaMuxReg = 32'd7;
    @(posedge clock); #1;
    bus.start = 1'b0;
    dn = 0; first = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clock);
      if (bus.done) begin
        dn++;
        if (first == 0) first = i;
      end
      if (i == 5) begin
        bus.start = 1'b1; bus.aluControl = 4'b1000; bus.readData1 = 32'd3; bus.saidaMuxReg = 32'd9;
      end
      if (i == 6) bus.start = 1'b0;
    end
    chk("ign_done_count", 64'(dn), 64'd1);
    chk("ign_latency", 64'(first), 64'd33);
    chk("ign_result", 64'({bus.aluResultHi, bus.aluResult}), {32'd2, 32'd14});
    prev_lo = 32'd14; prev_hi = 32'd2;

    // start held high: back-to-back ops with one idle cycle between done pulses
    @(negedge clock);
    bus.start = 1'b1; bus.aluControl = 4'b0010; bus.readData1 = 32'd10; bus.saidaMuxReg = 32'd20;
    dn = 0; first = 0; second = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      if (bus.done) begin
        dn++;
        if (first == 0) first = i;
        else if (second == 0) second = i;
      end
    end
    bus.start = 1'b0;
    chk("held_done_count", 64'(dn), 64'd3);
    chk("held_spacing", 64'(second - first), 64'd2);
    chk("held_result", 64'(bus.aluResult), 64'd30);
    @(negedge clock);
    prev_lo = 32'd30; prev_hi = '0;

    for (int i = 0; i < 16; i++) begin
      rop = codes[$urandom_range(0, 9)];
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, $sformatf("rnd%0d_op%0h", i, rop));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
